pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. Each cycle it decides whether the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers hold, advance or take a bubble. It covers load-use hazards, taken jumps/branches resolved in EXE, and data-cache misses in MEM. It drives the `freeze` inputs of the stage registers, including ID/EXE, and keeps saturating stall/flush counters for debug `$display` dumps.

## Interface
Parameters:
- `MISS_TIMEOUT`, 64: maximum cycles spent in MISS_WAIT before `miss_error` is raised.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_b`  in  1  asynchronous, active-high reset. The name is kept for consistency with the other pipeline blocks; asserting it high resets the block.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads `rt` as a source (R-type, SB, BEQ).
- `exe_dst`  in  5  destination register of the instruction in EXE, after `reg_dst` muxing.
- `exe_reg_write`, `exe_mem_to_reg`  in  1 each  EXE instruction writes a register / is a load.
- `exe_jump_taken`  in  1  EXE resolved a taken jump or branch this cycle.
- `mem_cache_en`  in  1  MEM instruction accesses the data cache.
- `cache_hit`  in  1  same-cycle hit indication, meaningful only while `mem_cache_en` is high.
- `mem_ready`  in  1  one-cycle pulse from the memory side when a refill completes.
- `pc_freeze`, `if_id_freeze`, `id_exe_freeze`, `exe_mem_freeze`  out  1 each  hold the corresponding register.
- `if_id_flush`, `id_exe_flush`  out  1 each  load a NOP bubble into the register on the next edge.
- `miss_error`  out  1  sticky; set when a miss exceeds `MISS_TIMEOUT`.
- `stall_cycles`, `flush_events`  out  `CNT_W` each  saturating counters.

## Operation
- FSM states: RUN, MISS_WAIT, MISS_RESUME. State is encoded in a 2-bit register.
- In RUN, a miss is `mem_cache_en & ~cache_hit`.
  - On a miss, assert all four freezes this cycle and go to MISS_WAIT.
  - Miss handling has the highest priority and suppresses every flush in the same cycle.
- In RUN, a taken jump is `exe_jump_taken` with no miss.
  - Assert `if_id_flush` and `id_exe_flush`; all freezes stay low.
  - A jump takes priority over a load-use hazard in the same cycle, because the hazarding instruction is itself squashed.
- In RUN, a load-use hazard is `exe_reg_write & exe_mem_to_reg & exe_dst != 0` and (`exe_dst == id_rs`, or `id_uses_rt & exe_dst == id_rt`), with no miss and no jump.
  - Assert `pc_freeze`, `if_id_freeze` and `id_exe_flush` for exactly that cycle.
  - `exe_mem_freeze` stays 0, so the load advances.
- If no condition holds in RUN, all outputs are 0.
- MISS_WAIT:
  - All four freezes are held high and all flushes are low.
  - A wait counter increments every cycle.
  - `mem_ready` moves the FSM to MISS_RESUME.
  - If the counter reaches `MISS_TIMEOUT - 1` without `mem_ready`, set `miss_error` and go to MISS_RESUME.
- MISS_RESUME:
  - Lasts exactly one cycle. Freezes stay high so the cache can present refilled data with `cache_hit = 1`.
  - The FSM then returns to RUN. The stalled instruction is re-evaluated in RUN; it does not bypass evaluation.
- Counters:
  - `stall_cycles` increments in every cycle in which `pc_freeze` is high.
  - `flush_events` increments on every cycle with `id_exe_flush` high.
  - Both saturate at all-ones and never wrap.
- Ignored inputs: `exe_jump_taken` is ignored outside RUN. The jump is re-presented after the freeze, because the EXE register holds.

## Timing
- Outputs are combinational from the current state and current inputs (Mealy in RUN, Moore in the MISS states). They must settle within the same cycle for the stage registers to sample.
- Load-use bubble: exactly 1 cycle of freeze. The dependent instruction reaches EXE two edges after the load does.
- Miss stall duration = (cycles until `mem_ready`) + 1 resume cycle.
- A `mem_ready` coincident with the miss-detect cycle is ignored; the FSM still enters MISS_WAIT.
- Reset, asynchronous high:
  - State is RUN, the wait counter is 0, `miss_error` is 0, and both perf counters are 0.
  - All freeze/flush outputs are 0 while reset is asserted.
- Reset mid-miss returns to RUN immediately, without a resume cycle.

## Structure
- A shared package (`pipeline_pkg`) holds the state enum `hz_state_t` (RUN, MISS_WAIT, MISS_RESUME) and the constant `REG_ZERO = 5'd0`.
- The same package holds `NOP_INST = 32'h0000_0000`, which the stage registers use when flushed.
- One sub-module, `sat_counter` (parameter `W`, ports clk/rst_b/inc/count), is instantiated twice for the perf counters.
- Hazard detection and the FSM live in the top module.

## Test plan
- Load-use: `exe_mem_to_reg = 1`, `exe_reg_write = 1`, `exe_dst = 5`, `id_rs = 5` -> one cycle with `pc_freeze = if_id_freeze = id_exe_flush = 1` and `exe_mem_freeze = 0`; `stall_cycles = 1`, `flush_events = 1`. Repeat with `exe_dst = 0` -> no stall.
- rt path: `id_rt = 7`, `exe_dst = 7`, `id_uses_rt = 0` -> no stall; with `id_uses_rt = 1` -> 1-cycle stall.
- Jump plus hazard: `exe_jump_taken = 1` together with a load-use match -> `if_id_flush = id_exe_flush = 1`, all freezes 0, `flush_events` +1.
- Cache miss: `mem_cache_en = 1`, `cache_hit = 0`, `mem_ready` pulsed 5 cycles later -> all four freezes high for 7 cycles (detect + 5 wait + resume), then RUN; `stall_cycles = 7`.
- Timeout: with `MISS_TIMEOUT = 4` and no `mem_ready` -> `miss_error` rises at the 4th wait cycle, one resume cycle follows, then RUN; `miss_error` stays 1 until reset.
- Reset mid-MISS_WAIT: raise `rst_b` asynchronously -> all outputs 0 immediately, counters 0; after release, a fresh miss enters MISS_WAIT normally.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline control blocks.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MISS_WAIT   = 2'd1,
    MISS_RESUME = 2'd2
  } hz_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // ID reads a register the load in EXE has not produced yet ($zero never hazards).
  function automatic logic load_use_match(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic uses_rt, input logic [4:0] dst);
    return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller's debug statistics.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, EXE-resolved jumps and D-cache miss freezes.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MISS_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       exe_dst,
  input  logic             exe_reg_write,
  input  logic             exe_mem_to_reg,
  input  logic             exe_jump_taken,
  input  logic             mem_cache_en,
  input  logic             cache_hit,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_freeze,
  output logic             exe_mem_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             miss_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WaitW = $clog2(MISS_TIMEOUT) + 1;

  hz_state_t        r_state, w_state_nxt;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_miss_error, w_miss_error_nxt;

  logic w_miss, w_jump, w_load_use, w_timeout;
  logic w_freeze_all, w_freeze_front, w_flush_both, w_flush_id_exe;

  assign w_miss     = mem_cache_en & ~cache_hit;
  assign w_jump     = exe_jump_taken & ~w_miss;
  assign w_load_use = exe_reg_write & exe_mem_to_reg & ~w_miss & ~w_jump &
                      load_use_match(id_rs, id_rt, id_uses_rt, exe_dst);
  assign w_timeout  = (r_wait_cnt == WaitW'(MISS_TIMEOUT - 1));

  always_comb begin
    w_state_nxt      = r_state;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_miss_error_nxt = r_miss_error;
    w_freeze_all     = 1'b0;
    w_freeze_front   = 1'b0;
    w_flush_both     = 1'b0;
    w_flush_id_exe   = 1'b0;
    unique case (r_state)
      RUN: begin
        w_wait_cnt_nxt = '0;
        if (w_miss) begin
          w_freeze_all = 1'b1;
          w_state_nxt  = MISS_WAIT;
        end else if (w_jump) begin
          w_flush_both = 1'b1;
        end else if (w_load_use) begin
          w_freeze_front = 1'b1;
          w_flush_id_exe = 1'b1;
        end
      end
      MISS_WAIT: begin
        w_freeze_all = 1'b1;
        if (mem_ready) begin
          w_state_nxt = MISS_RESUME;
        end else if (w_timeout) begin
          w_miss_error_nxt = 1'b1;
          w_state_nxt      = MISS_RESUME;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WaitW'(1);
        end
      end
      MISS_RESUME: begin
        // One more frozen cycle so the refilled line is visible as a hit.
        w_freeze_all = 1'b1;
        w_state_nxt  = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_miss_error <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_miss_error <= w_miss_error_nxt;
    end
  end

  // Outputs are Mealy in RUN, so gate them while reset is held.
  assign pc_freeze      = (w_freeze_all | w_freeze_front) & ~rst_b;
  assign if_id_freeze   = (w_freeze_all | w_freeze_front) & ~rst_b;
  assign id_exe_freeze  = w_freeze_all & ~rst_b;
  assign exe_mem_freeze = w_freeze_all & ~rst_b;
  assign if_id_flush    = w_flush_both & ~rst_b;
  assign id_exe_flush   = (w_flush_both | w_flush_id_exe) & ~rst_b;
  assign miss_error     = r_miss_error;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (pc_freeze),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (id_exe_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus randomized run against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [4:0] id_rs, id_rt, exe_dst;
  logic       id_uses_rt, exe_reg_write, exe_mem_to_reg, exe_jump_taken;
  logic       mem_cache_en, cache_hit, mem_ready;

  logic        a_pc, a_ifid, a_idexe, a_exemem, a_iff, a_idf, a_err;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_ifid, b_idexe, b_exemem, b_iff, b_idf, b_err;
  logic [2:0]  b_stall, b_flush;
  logic [6:0]  out_a, out_b;

  int checks = 0;
  int failures = 0;

  // Behavioural model state, one slot per DUT instance.
  bit m_miss[2], m_res[2], m_err[2];
  int m_wait[2], m_stall[2], m_flush[2];
  int m_tmo[2] = '{64, 4};
  int m_max[2] = '{65535, 7};

  assign out_a = {a_pc, a_ifid, a_idexe, a_exemem, a_iff, a_idf, a_err};
  assign out_b = {b_pc, b_ifid, b_idexe, b_exemem, b_iff, b_idf, b_err};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst_b(rst_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .exe_dst(exe_dst), .exe_reg_write(exe_reg_write), .exe_mem_to_reg(exe_mem_to_reg),
    .exe_jump_taken(exe_jump_taken), .mem_cache_en(mem_cache_en), .cache_hit(cache_hit),
    .mem_ready(mem_ready), .pc_freeze(a_pc), .if_id_freeze(a_ifid), .id_exe_freeze(a_idexe),
    .exe_mem_freeze(a_exemem), .if_id_flush(a_iff), .id_exe_flush(a_idf), .miss_error(a_err),
    .stall_cycles(a_stall), .flush_events(a_flush)
  );

  pipeline_hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_b(rst_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .exe_dst(exe_dst), .exe_reg_write(exe_reg_write), .exe_mem_to_reg(exe_mem_to_reg),
    .exe_jump_taken(exe_jump_taken), .mem_cache_en(mem_cache_en), .cache_hit(cache_hit),
    .mem_ready(mem_ready), .pc_freeze(b_pc), .if_id_freeze(b_ifid), .id_exe_freeze(b_idexe),
    .exe_mem_freeze(b_exemem), .if_id_flush(b_iff), .id_exe_flush(b_idf), .miss_error(b_err),
    .stall_cycles(b_stall), .flush_events(b_flush)
  );

  task automatic set_idle();
    id_rs = 0; id_rt = 0; exe_dst = 0; id_uses_rt = 0; exe_reg_write = 0;
    exe_mem_to_reg = 0; exe_jump_taken = 0; mem_cache_en = 0; cache_hit = 0; mem_ready = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    set_idle();
    rst_b = 1'b1;
    #2 rst_b = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] dst);
    exe_reg_write = 1; exe_mem_to_reg = 1; exe_dst = dst;
  endtask

  // Expected {pc, if_id, id_exe, exe_mem freezes, if_id flush, id_exe flush, miss_error}.
  function automatic logic [6:0] exp_out(input int k);
    bit lu;
    if (m_miss[k] || m_res[k]) return {4'b1111, 2'b00, m_err[k]};
    if (mem_cache_en && !cache_hit) return {4'b1111, 2'b00, m_err[k]};
    if (exe_jump_taken) return {4'b0000, 2'b11, m_err[k]};
    lu = exe_reg_write && exe_mem_to_reg && exe_dst != 0 &&
         (exe_dst == id_rs || (id_uses_rt && exe_dst == id_rt));
    if (lu) return {4'b1100, 2'b01, m_err[k]};
    return {6'b0, m_err[k]};
  endfunction

  task automatic model_step(input int k);
    logic [6:0] o;
    o = exp_out(k);
    if (o[6] && m_stall[k] < m_max[k]) m_stall[k]++;
    if (o[1] && m_flush[k] < m_max[k]) m_flush[k]++;
    if (m_res[k]) begin
      m_res[k] = 0;
    end else if (m_miss[k]) begin
      m_wait[k]++;
      if (mem_ready) begin
        m_miss[k] = 0; m_res[k] = 1;
      end else if (m_wait[k] >= m_tmo[k]) begin
        m_err[k] = 1; m_miss[k] = 0; m_res[k] = 1;
      end
    end else if (mem_cache_en && !cache_hit) begin
      m_miss[k] = 1; m_wait[k] = 0;
    end
  endtask

  task automatic test_reset();
    set_idle();
    exe_jump_taken = 1;
    rst_b = 1'b1;
    #1;
    checks++;
    if (out_a !== 7'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want %b", out_a, 7'b0);
    end
    checks++;
    if (a_stall !== 16'd0 || a_flush !== 16'd0) begin
      failures++; $display("FAIL reset_counters: got %0d/%0d want 0/0", a_stall, a_flush);
    end
    @(negedge clk);
    set_idle();
    rst_b = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clk); set_load(5); id_rs = 5; #1;
    checks++;
    if (out_a !== 7'b1100010) begin
      failures++; $display("FAIL load_use_stall: got %b want %b", out_a, 7'b1100010);
    end
    @(negedge clk); set_idle(); #1;
    checks++;
    if (out_a !== 7'b0 || a_stall !== 16'd1 || a_flush !== 16'd1) begin
      failures++; $display("FAIL load_use_release: got %b %0d/%0d want 0 1/1", out_a, a_stall, a_flush);
    end
    @(negedge clk); set_load(0); id_rs = 0; #1;
    checks++;
    if (out_a !== 7'b0) begin
      failures++; $display("FAIL load_use_r0: got %b want %b", out_a, 7'b0);
    end
  endtask

  task automatic test_rt_path();
    @(negedge clk); set_idle(); set_load(7); id_rs = 3; id_rt = 7; id_uses_rt = 0; #1;
    checks++;
    if (out_a !== 7'b0) begin
      failures++; $display("FAIL rt_unused: got %b want %b", out_a, 7'b0);
    end
    @(negedge clk); id_uses_rt = 1; #1;
    checks++;
    if (out_a !== 7'b1100010) begin
      failures++; $display("FAIL rt_used: got %b want %b", out_a, 7'b1100010);
    end
    @(negedge clk); set_idle(); #1;
    checks++;
    if (a_stall !== 16'd2 || a_flush !== 16'd2) begin
      failures++; $display("FAIL rt_counters: got %0d/%0d want 2/2", a_stall, a_flush);
    end
  endtask

  task automatic test_jump_priority();
    @(negedge clk); set_load(9); id_rs = 9; exe_jump_taken = 1; #1;
    checks++;
    if (out_a !== 7'b0000110) begin
      failures++; $display("FAIL jump_over_load_use: got %b want %b", out_a, 7'b0000110);
    end
    @(negedge clk); set_idle(); #1;
    checks++;
    if (a_flush !== 16'd3 || a_stall !== 16'd2) begin
      failures++; $display("FAIL jump_counters: got %0d/%0d want stall 2 flush 3", a_stall, a_flush);
    end
  endtask

  task automatic test_cache_miss();
    // Coincident mem_ready on the detect cycle must not short-cut the wait.
    @(negedge clk); mem_cache_en = 1; cache_hit = 0; mem_ready = 1; exe_jump_taken = 1; #1;
    checks++;
    if (out_a !== 7'b1111000) begin
      failures++; $display("FAIL miss_detect: got %b want %b", out_a, 7'b1111000);
    end
    for (int w = 1; w <= 5; w++) begin
      @(negedge clk); mem_ready = (w == 5); exe_jump_taken = (w == 2); #1;
      checks++;
      if (out_a !== 7'b1111000) begin
        failures++; $display("FAIL miss_wait%0d: got %b want %b", w, out_a, 7'b1111000);
      end
    end
    @(negedge clk); mem_ready = 0; exe_jump_taken = 0; cache_hit = 1; #1;
    checks++;
    if (out_a !== 7'b1111000) begin
      failures++; $display("FAIL miss_resume: got %b want %b", out_a, 7'b1111000);
    end
    @(negedge clk); #1;
    checks++;
    if (out_a !== 7'b0 || a_stall !== 16'd9) begin
      failures++; $display("FAIL miss_back_to_run: got %b stall %0d want 0 stall 9", out_a, a_stall);
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    @(negedge clk); mem_cache_en = 1; cache_hit = 0; #1;
    checks++;
    if (out_b !== 7'b1111000) begin
      failures++; $display("FAIL tmo_detect: got %b want %b", out_b, 7'b1111000);
    end
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk); #1;
      checks++;
      if (out_b[6:1] !== 6'b111100 || (w < 4 && b_err !== 1'b0)) begin
        failures++; $display("FAIL tmo_wait%0d: got %b want 111100x (err 0 before 4th)", w, out_b);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (out_b !== 7'b1111001) begin
      failures++; $display("FAIL tmo_resume: got %b want %b", out_b, 7'b1111001);
    end
    @(negedge clk); mem_cache_en = 0; #1;
    checks++;
    if (out_b !== 7'b0000001) begin
      failures++; $display("FAIL tmo_run: got %b want %b", out_b, 7'b0000001);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (b_err !== 1'b1) begin
      failures++; $display("FAIL tmo_sticky: got %b want 1", b_err);
    end
  endtask

  task automatic test_reset_mid_miss();
    pulse_reset();
    @(negedge clk); mem_cache_en = 1; cache_hit = 0; #1;
    @(negedge clk); #1;
    checks++;
    if (out_a !== 7'b1111000) begin
      failures++; $display("FAIL mid_wait: got %b want %b", out_a, 7'b1111000);
    end
    #2 rst_b = 1'b1;
    #1;
    checks++;
    if (out_a !== 7'b0 || out_b !== 7'b0 || a_stall !== 16'd0) begin
      failures++; $display("FAIL mid_reset: got %b %b stall %0d want 0 0 0", out_a, out_b, a_stall);
    end
    @(negedge clk); set_idle(); rst_b = 1'b0; #1;
    checks++;
    if (out_a !== 7'b0) begin
      failures++; $display("FAIL mid_no_resume: got %b want %b", out_a, 7'b0);
    end
    @(negedge clk); mem_cache_en = 1; cache_hit = 0; #1;
    @(negedge clk); mem_ready = 1; #1;
    checks++;
    if (out_a !== 7'b1111000) begin
      failures++; $display("FAIL fresh_wait: got %b want %b", out_a, 7'b1111000);
    end
    @(negedge clk); mem_ready = 0; cache_hit = 1; #1;
    @(negedge clk); #1;
    checks++;
    if (out_a !== 7'b0 || a_stall !== 16'd3) begin
      failures++; $display("FAIL fresh_done: got %b stall %0d want 0 stall 3", out_a, a_stall);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); set_load(12); id_rs = 12;
    end
    @(negedge clk); set_idle(); #1;
    checks++;
    if (b_stall !== 3'd7 || b_flush !== 3'd7) begin
      failures++; $display("FAIL sat_small: got %0d/%0d want 7/7", b_stall, b_flush);
    end
    checks++;
    if (a_stall !== 16'd10 || a_flush !== 16'd10) begin
      failures++; $display("FAIL sat_wide: got %0d/%0d want 10/10", a_stall, a_flush);
    end
  endtask

  task automatic test_random();
    logic [6:0] ea, eb;
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      m_miss[k] = 0; m_res[k] = 0; m_err[k] = 0; m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      exe_dst = 5'($urandom_range(0, 3)); id_uses_rt = 1'($urandom_range(0, 1));
      exe_reg_write = ($urandom_range(0, 3) != 0); exe_mem_to_reg = ($urandom_range(0, 1) != 0);
      exe_jump_taken = ($urandom_range(0, 6) == 0); mem_cache_en = ($urandom_range(0, 3) == 0);
      cache_hit = ($urandom_range(0, 2) != 0); mem_ready = ($urandom_range(0, 5) == 0);
      #1;
      ea = exp_out(0);
      eb = exp_out(1);
      checks++;
      if (out_a !== ea || a_stall !== 16'(m_stall[0]) || a_flush !== 16'(m_flush[0])) begin
        failures++;
        $display("FAIL rand_a cyc %0d: got %b %0d/%0d want %b %0d/%0d", c, out_a, a_stall,
                 a_flush, ea, m_stall[0], m_flush[0]);
      end
      checks++;
      if (out_b !== eb || b_stall !== 3'(m_stall[1]) || b_flush !== 3'(m_flush[1])) begin
        failures++;
        $display("FAIL rand_b cyc %0d: got %b %0d/%0d want %b %0d/%0d", c, out_b, b_stall,
                 b_flush, eb, m_stall[1], m_flush[1]);
      end
      model_step(0);
      model_step(1);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_path();
    test_jump_priority();
    test_cache_miss();
    test_timeout();
    test_reset_mid_miss();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
